// File: rtl/crc_frame_checker.sv
// crc_frame_checker: receive-side serial CRC checker.
// Consumes a frame of data_len data bits followed by a WIDTH-bit CRC, MSB first,
// one bit per bit_valid strobe. Recomputes the CRC (non-reflected, no final XOR)
// with the polynomial/init sampled at frame_start, and pulses done with crc_ok or
// crc_err once the last CRC bit is consumed. Saturating good/bad frame counters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   crc_poly, crc_init       polynomial (x^WIDTH implicit) and preset, sampled at frame_start
//   data_len                 data bits in frame, sampled at frame_start
//   frame_start              starts a frame (aborts any frame in progress)
//   bit_valid, bit_in        serial bit strobe and bit
//   busy                     frame in progress (DATA/CHECK/RESULT)
//   done, crc_ok, crc_err    one-cycle result pulse and verdict
//   crc_calc, crc_rx         computed and received CRC, held until next frame_start
//   good_cnt, bad_cnt        saturating frame counters
module crc_frame_checker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] crc_poly,
    input  logic [WIDTH-1:0] crc_init,
    input  logic [LEN_W-1:0] data_len,
    input  logic             frame_start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [WIDTH-1:0] crc_calc,
    output logic [WIDTH-1:0] crc_rx,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    // One counter serves both the data phase and the CRC phase.
    localparam int unsigned CRC_CW = $clog2(WIDTH + 1);
    localparam int unsigned BC_W   = (LEN_W > CRC_CW) ? LEN_W : CRC_CW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CHECK,
        S_RESULT
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  poly_q, poly_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BC_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  calc_q, calc_d;
    logic [WIDTH-1:0]  rx_q, rx_d;
    logic [CNT_W-1:0]  good_q, good_d;
    logic [CNT_W-1:0]  bad_q, bad_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              fb;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            poly_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            calc_q  <= '0;
            rx_q    <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            poly_q  <= poly_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            calc_q  <= calc_d;
            rx_q    <= rx_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. The verdict and counter update are registered on the edge
    // that consumes the last CRC bit, so they are visible during RESULT.
    always_comb begin
        state_d = state_q;
        poly_d  = poly_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        calc_d  = calc_q;
        rx_d    = rx_q;
        good_d  = good_q;
        bad_d   = bad_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        fb      = calc_q[WIDTH-1] ^ bit_in;

        if (frame_start) begin
            // New frame from any state; a frame in progress is dropped silently.
            poly_d  = crc_poly;
            len_d   = data_len;
            calc_d  = crc_init;
            rx_d    = '0;
            cnt_d   = '0;
            state_d = (data_len == '0) ? S_CHECK : S_DATA;
        end else begin
            case (state_q)
                S_DATA: begin
                    if (bit_valid) begin
                        calc_d = {calc_q[WIDTH-2:0], 1'b0} ^ (fb ? poly_q : '0);
                        if (cnt_q == BC_W'(len_q) - BC_W'(1)) begin
                            cnt_d   = '0;
                            state_d = S_CHECK;
                        end else begin
                            cnt_d = cnt_q + BC_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (bit_valid) begin
                        rx_d = {rx_q[WIDTH-2:0], bit_in};
                        if (cnt_q == BC_W'(WIDTH - 1)) begin
                            cnt_d   = '0;
                            state_d = S_RESULT;
                            done_d  = 1'b1;
                            ok_d    = (calc_q == rx_d);
                            err_d   = (calc_q != rx_d);
                            if (calc_q == rx_d) begin
                                if (good_q != '1) good_d = good_q + CNT_W'(1);
                            end else begin
                                if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + BC_W'(1);
                        end
                    end
                end
                S_RESULT: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign crc_ok   = ok_q;
    assign crc_err  = err_q;
    assign crc_calc = calc_q;
    assign crc_rx   = rx_q;
    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;

endmodule
